// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared frame field widths for the SPI master and its request bus
// Purpose: default address/data widths of the SPI write frame.
// Ports: none (package).
package spi_pkg;
  localparam int AWIDTH = 8;
  localparam int DWIDTH = 32;
endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - request/response bus between a requester and spi_master
// Purpose: groups the start/busy/done handshake, frame fields and mode select.
// Signals:
//   cfg_mode[1:0]  [1]=CPOL, [0]=CPHA, sampled when start is accepted
//   start          request strobe, accepted only while busy=0
//   write, size, addr, wdata   frame fields
//   busy, done     transaction status, done is a one-cycle end-of-frame pulse
//   rdata          captured miso data (zero unless read capture is built in)
// Modports: master = requester side, slave = spi_master side.
interface spi_master_if #(
  parameter int AWIDTH = spi_pkg::AWIDTH,
  parameter int DWIDTH = spi_pkg::DWIDTH
) ();
  logic [1:0]        cfg_mode;
  logic              start;
  logic              write;
  logic [1:0]        size;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DWIDTH-1:0] rdata;

  modport master (
    output cfg_mode, start, write, size, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  cfg_mode, start, write, size, addr, wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI write-frame initiator with per-request CPOL/CPHA mode
// Purpose: shifts {write, size[1:0], addr, wdata} MSB first to the SPI memory
//   slave inside one ss_n window, in any of the four SPI modes, then holds a
//   minimum deselect gap before the next request can be accepted.
// Optional feature: define SPI_MASTER_READ_EN to shift miso into a capture
//   register during the data bits and present it on rdata with done.
// Ports:
//   clk    in   system clock, all logic on posedge
//   rst_n  in   asynchronous active-low reset
//   req    bus  spi_master_if.slave: cfg_mode/start/write/size/addr/wdata in,
//               busy/done/rdata out
//   sck    out  SPI clock
//   mosi   out  SPI serial out
//   miso   in   SPI serial in (only used with SPI_MASTER_READ_EN)
//   ss_n   out  slave select, active low
module spi_master #(
  parameter int AWIDTH  = spi_pkg::AWIDTH,
  parameter int DWIDTH  = spi_pkg::DWIDTH,
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_master_if.slave req,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        ss_n
);
  localparam int NBITS = AWIDTH + 3 + DWIDTH;
  localparam int EW    = $clog2(2 * NBITS);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [EW-1:0]    edge_cnt_q, edge_cnt_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             ss_n_q, ss_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tick;
  logic             last_edge;
  logic             lead_edge;
  logic             accept;
  logic [NBITS-1:0] frame;

  assign frame     = {req.write, req.size, req.addr, req.wdata};
  assign accept    = (state_q == IDLE) && req.start && !busy_q;
  assign tick      = (state_q != IDLE) && (cnt_q == 8'(CLK_DIV - 1));
  assign last_edge = (edge_cnt_q == EW'(2 * NBITS - 1));
  // sck starts each frame at CPOL, so even toggles leave CPOL.
  assign lead_edge = ~edge_cnt_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (tick) state_d = SHIFT;
      SHIFT:   if (tick && last_edge) state_d = HOLD;
      HOLD:    if (tick) state_d = GAP;
      GAP:     if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = '0;
    edge_cnt_d = '0;
    shreg_d    = shreg_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Half-period counter wraps on tick and restarts on every state change.
    if (state_q != IDLE && state_d == state_q && !tick) cnt_d = cnt_q + 8'd1;
    if (state_q == SHIFT && state_d == SHIFT)
      edge_cnt_d = tick ? edge_cnt_q + EW'(1) : edge_cnt_q;

    case (state_q)
      IDLE: begin
        sck_d = req.cfg_mode[1];
        if (accept) begin
          cpol_d = req.cfg_mode[1];
          cpha_d = req.cfg_mode[0];
          ss_n_d = 1'b0;
          busy_d = 1'b1;
          if (req.cfg_mode[0]) begin
            shreg_d = frame;
          end else begin
            // CPHA=0: the first bit must already be on mosi at the first leading edge.
            mosi_d  = frame[NBITS-1];
            shreg_d = {frame[NBITS-2:0], 1'b0};
          end
        end else if (busy_q) begin
          busy_d = 1'b0;
        end
      end
      SETUP: sck_d = cpol_q;
      SHIFT: begin
        if (tick) begin
          sck_d = ~sck_q;
          if ((lead_edge && cpha_q) || (!lead_edge && !cpha_q && !last_edge)) begin
            mosi_d  = shreg_q[NBITS-1];
            shreg_d = {shreg_q[NBITS-2:0], 1'b0};
          end
        end
      end
      HOLD: begin
        sck_d = cpol_q;
        if (tick) begin
          ss_n_d = 1'b1;
          done_d = 1'b1;
        end
      end
      GAP: begin
        sck_d = cpol_q;
        if (tick) mosi_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      shreg_q    <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      shreg_q    <= shreg_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;
  assign req.busy = busy_q;
  assign req.done = done_q;

`ifdef SPI_MASTER_READ_EN
  logic [DWIDTH-1:0] cap_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              sample;
  logic              in_data;

  // Sample edge is the leading edge for CPHA=0 and the trailing edge for CPHA=1.
  assign sample  = (state_q == SHIFT) && tick && (lead_edge ^ cpha_q);
  // Two toggles per bit: the data bits start at toggle 2*(AWIDTH+3).
  assign in_data = (edge_cnt_q >= EW'(2 * (AWIDTH + 3)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (sample && in_data) cap_q <= {cap_q[DWIDTH-2:0], miso};
      if (state_q == HOLD && tick) rdata_q <= cap_q;
    end
  end

  assign req.rdata = rdata_q;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign req.rdata   = '0;
`endif
endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;
  import spi_pkg::*;

  localparam int NB = AWIDTH + 3 + DWIDTH;
  localparam logic [DWIDTH-1:0] PAT = 32'hA5A50F0F;
`ifdef SPI_MASTER_READ_EN
  localparam logic [DWIDTH-1:0] RD_EXP = 32'hA5A50F0F;
`else
  localparam logic [DWIDTH-1:0] RD_EXP = '0;
`endif
  localparam logic [NB-1:0] FRAME_A = {1'b1, 2'b10, 8'h14, 32'hDEADBEEF};
  localparam logic [NB-1:0] FRAME_B = {1'b1, 2'b10, 8'h30, 32'h12345678};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] sck_w, mosi_w, ss_w, miso_w, busy_w, done_w;

  spi_master_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) if0 ();
  spi_master_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) if1 ();

  spi_master #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .CLK_DIV(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(if0),
    .sck(sck_w[0]), .mosi(mosi_w[0]), .miso(miso_w[0]), .ss_n(ss_w[0])
  );

  spi_master #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .CLK_DIV(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(if1),
    .sck(sck_w[1]), .mosi(mosi_w[1]), .miso(miso_w[1]), .ss_n(ss_w[1])
  );

  assign busy_w = {if1.busy, if0.busy};
  assign done_w = {if1.done, if0.done};

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model / monitor state, one slot per DUT, only written at negedge.
  logic [1:0]        mode_r [2];
  logic [63:0]       rx_sr [2];
  logic [NB-1:0]     last_frame [2];
  int                rx_cnt [2], rises [2], edges [2], frames [2], done_cnt [2];
  int                mosi_age [2], setup_viol [2], ss_high [2], last_gap [2];
  int                busy_run [2], last_busy [2], prev_busy [2];
  logic [1:0]        sck_p = 2'b00, ss_p = 2'b11, mosi_p = 2'b00;
  logic [DWIDTH-1:0] rd_done0 = '0;
  logic [DWIDTH-1:0] mem [0:63];
  logic [DWIDTH-1:0] pat_v;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rx_sr[i] = '0; last_frame[i] = '0; rx_cnt[i] = 0; rises[i] = 0; edges[i] = 0;
      frames[i] = 0; done_cnt[i] = 0; mosi_age[i] = 0; setup_viol[i] = 0;
      ss_high[i] = 1000; last_gap[i] = 0; busy_run[i] = 0; last_busy[i] = 0; prev_busy[i] = 0;
    end
    miso_w = 2'b00;
    pat_v  = PAT;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mosi_w[i] != mosi_p[i]) mosi_age[i] = 0;
      else mosi_age[i]++;
      if (!ss_w[i] && ss_p[i]) begin
        last_gap[i] = ss_high[i];
        rx_cnt[i] = 0; rises[i] = 0; edges[i] = 0; setup_viol[i] = 0;
      end
      if (!ss_w[i] && sck_w[i] != sck_p[i]) begin
        edges[i]++;
        if (sck_w[i]) rises[i]++;
        if (sck_w[i] == ~(mode_r[i][1] ^ mode_r[i][0])) begin
          if (mosi_age[i] < ((i == 0) ? 4 : 2)) setup_viol[i]++;
          rx_sr[i] = {rx_sr[i][62:0], mosi_w[i]};
          rx_cnt[i]++;
        end
      end
      if (ss_w[i] && !ss_p[i]) begin
        // Only a complete frame is committed; a partial one is discarded.
        if (rx_cnt[i] == NB) begin
          frames[i]++;
          last_frame[i] = rx_sr[i][NB-1:0];
          if (i == 0 && rx_sr[i][NB-1]) mem[rx_sr[i][DWIDTH+7:DWIDTH+2]] = rx_sr[i][DWIDTH-1:0];
        end
        rx_cnt[i] = 0;
        ss_high[i] = 1;
      end else if (ss_w[i]) begin
        ss_high[i]++;
      end
      if (busy_w[i]) busy_run[i]++;
      else if (busy_run[i] > 0) begin
        prev_busy[i] = last_busy[i];
        last_busy[i] = busy_run[i];
        busy_run[i]  = 0;
      end
      if (done_w[i]) begin
        done_cnt[i]++;
        if (i == 0) rd_done0 = if0.rdata;
      end
      // Slave returns PAT MSB first during the data bits of the frame.
      if (!ss_w[i] && rx_cnt[i] >= AWIDTH + 3 && rx_cnt[i] < NB) miso_w[i] = pat_v[NB-1-rx_cnt[i]];
      else miso_w[i] = 1'b0;
      sck_p[i]  = sck_w[i];
      ss_p[i]   = ss_w[i];
      mosi_p[i] = mosi_w[i];
    end
  end

  task automatic wait_idle0(output bit ok);
    int n;
    n = 0;
    while (busy_w[0] && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    ok = (n < 1000);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic send0(input logic [1:0] mode, input logic [NB-1:0] frame, output bit ok);
    @(posedge clk); #2;
    if0.cfg_mode = mode;
    mode_r[0] = mode;
    repeat (2) @(posedge clk);
    #2;
    check_eq($sformatf("m%0d_idle_sck", mode), sck_w[0], mode[1]);
    {if0.write, if0.size, if0.addr, if0.wdata} = frame;
    if0.start = 1'b1;
    @(posedge clk); #2;
    if0.start = 1'b0;
    wait_idle0(ok);
  endtask

  initial begin
    int  f0, d0, f1, n;
    bit  ok;
    if0.cfg_mode = 2'b00; if0.start = 1'b0; if0.write = 1'b0; if0.size = '0; if0.addr = '0; if0.wdata = '0;
    if1.cfg_mode = 2'b00; if1.start = 1'b0; if1.write = 1'b0; if1.size = '0; if1.addr = '0; if1.wdata = '0;
    mode_r[0] = 2'b00;
    mode_r[1] = 2'b00;

    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_busy", busy_w[0], 1'b0);
    check_eq("rst_done", done_w[0], 1'b0);
    check_eq("rst_ss_n", ss_w[0], 1'b1);
    check_eq("rst_sck", sck_w[0], 1'b0);
    check_eq("rst_mosi", mosi_w[0], 1'b0);
    check_eq("rst_rdata", if0.rdata, '0);
    rst_n = 1'b1;

    for (int m = 0; m < 4; m++) begin
      f0 = frames[0];
      d0 = done_cnt[0];
      send0(2'(m), FRAME_A, ok);
      check_eq($sformatf("m%0d_timeout", m), ok, 1'b1);
      check_eq($sformatf("m%0d_busy_len", m), last_busy[0], 357);
      check_eq($sformatf("m%0d_done_cnt", m), done_cnt[0] - d0, 1);
      check_eq($sformatf("m%0d_frames", m), frames[0] - f0, 1);
      check_eq($sformatf("m%0d_frame", m), last_frame[0], FRAME_A);
      check_eq($sformatf("m%0d_sck_rises", m), rises[0], 43);
      check_eq($sformatf("m%0d_mosi_setup", m), setup_viol[0], 0);
      check_eq($sformatf("m%0d_rdata", m), rd_done0, RD_EXP);
      check_eq($sformatf("m%0d_sck_after", m), sck_w[0], m[1]);
      if (m == 0) check_eq("mem5", mem[5], 32'hDEADBEEF);
    end

    // Extra starts while busy must be dropped.
    f0 = frames[0];
    if0.cfg_mode = 2'b00; mode_r[0] = 2'b00;
    {if0.write, if0.size, if0.addr, if0.wdata} = FRAME_A;
    if0.start = 1'b1;
    @(posedge clk); #2;
    if0.start = 1'b0;
    {if0.write, if0.size, if0.addr, if0.wdata} = FRAME_B;
    for (int k = 0; k < 3; k++) begin
      repeat (20) @(posedge clk);
      #2;
      if0.start = 1'b1;
      @(posedge clk); #2;
      if0.start = 1'b0;
    end
    wait_idle0(ok);
    check_eq("ign_timeout", ok, 1'b1);
    check_eq("ign_frames", frames[0] - f0, 1);
    check_eq("ign_frame", last_frame[0], FRAME_A);
    send0(2'b00, FRAME_B, ok);
    check_eq("gap_frame", last_frame[0], FRAME_B);
    check_eq("gap_min4", last_gap[0] >= 4, 1'b1);

    // Asynchronous reset in the middle of SHIFT.
    f0 = frames[0];
    d0 = done_cnt[0];
    if0.cfg_mode = 2'b10; mode_r[0] = 2'b10;
    repeat (2) @(posedge clk);
    #2;
    {if0.write, if0.size, if0.addr, if0.wdata} = FRAME_A;
    if0.start = 1'b1;
    @(posedge clk); #2;
    if0.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n = 0;
    while (edges[0] < 20 && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("rst_reach_edge20", n < 1000, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_ss_n", ss_w[0], 1'b1);
    check_eq("arst_sck", sck_w[0], 1'b0);
    check_eq("arst_busy", busy_w[0], 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check_eq("arst_no_done", done_cnt[0] - d0, 0);
    check_eq("arst_discard", frames[0] - f0, 0);
    send0(2'b00, FRAME_A, ok);
    check_eq("post_rst_frames", frames[0] - f0, 1);
    check_eq("post_rst_frame", last_frame[0], FRAME_A);

    // CLK_DIV=2 with start held high for back-to-back frames.
    f1 = frames[1];
    {if1.write, if1.size, if1.addr, if1.wdata} = FRAME_B;
    if1.start = 1'b1;
    n = 0;
    while (frames[1] < f1 + 2 && n < 2000) begin
      @(posedge clk); #2;
      n++;
    end
    if1.start = 1'b0;
    check_eq("b2b_two_frames", n < 2000, 1'b1);
    n = 0;
    while (busy_w[1] && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    check_eq("b2b_timeout", n < 1000, 1'b1);
    check_eq("b2b_busy_len1", prev_busy[1], 179);
    check_eq("b2b_busy_len2", last_busy[1], 179);
    check_eq("b2b_frame", last_frame[1], FRAME_B);
    check_eq("b2b_gap", last_gap[1] >= 2, 1'b1);
    check_eq("b2b_mosi_setup", setup_viol[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
